// File: rtl/serialize_ctrl_fsm.sv
// rtl/serialize_ctrl_fsm.sv - commit-stage sequencer for FENCE, FENCE.I and serializing CSR ops
// Define SERIALIZE_PERF_EN to build the completed-sequence and busy-cycle perf counters.
module serialize_ctrl_fsm #(
   parameter int ADDR_W         = 64,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int PERF_W         = 32
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              req_valid_i,
   input  logic [1:0]        req_type_i,
   input  logic [ADDR_W-1:0] req_pc_i,
   output logic              req_ready_o,
   input  logic              gl_empty_i,
   input  logic              sb_empty_i,
   output logic              drain_mem_o,
   output logic              icache_inv_req_o,
   input  logic              icache_inv_ack_i,
   input  logic              xcpt_flush_i,
   output logic              stall_fetch_o,
   output logic              flush_o,
   output logic              redirect_valid_o,
   output logic [ADDR_W-1:0] redirect_pc_o,
   output logic              busy_o,
   output logic              timeout_o,
   output logic [PERF_W-1:0] perf_serial_cnt_o,
   output logic [PERF_W-1:0] perf_stall_cnt_o
);

   localparam int              WD_W         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST      = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_SAT       = WD_W'(TIMEOUT_CYCLES);
   localparam logic [1:0]      TYPE_FENCE_I = 2'd1;
   localparam logic [1:0]      TYPE_CSR     = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_INVAL,
      S_FLUSH
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        type_q, type_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              xcpt_pend_q, xcpt_pend_d;
   logic              accept;
   logic              is_fence_i;
   logic              is_csr;
   logic              drain_done;

   assign is_fence_i    = (type_q == TYPE_FENCE_I);
   assign is_csr        = (type_q == TYPE_CSR);
   assign req_ready_o   = (state_q == S_IDLE) & ~xcpt_flush_i;
   assign accept        = req_valid_i & req_ready_o;
   assign drain_done    = gl_empty_i & (sb_empty_i | is_csr);
   assign busy_o        = (state_q != S_IDLE);
   assign redirect_pc_o = pc_q;

   always_comb begin
      state_d          = state_q;
      type_d           = type_q;
      pc_d             = pc_q;
      wd_d             = wd_q;
      xcpt_pend_d      = xcpt_pend_q;
      stall_fetch_o    = 1'b0;
      drain_mem_o      = 1'b0;
      icache_inv_req_o = 1'b0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      timeout_o        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_DRAIN;
               type_d  = req_type_i;
               pc_d    = req_pc_i + ADDR_W'(4);
            end
         end
         S_DRAIN: begin
            stall_fetch_o = 1'b1;
            drain_mem_o   = ~is_csr;
            timeout_o     = (wd_q == WD_LAST);
            if (wd_q != WD_SAT) begin
               wd_d = wd_q + WD_W'(1);
            end
            if (xcpt_flush_i) begin
               state_d = S_IDLE;
            end else if (drain_done) begin
               state_d = is_fence_i ? S_INVAL : S_FLUSH;
            end
            if (xcpt_flush_i || drain_done) begin
               wd_d = '0;
            end
         end
         S_INVAL: begin
            // An exception seen mid-invalidate is remembered; the cache still needs its ack.
            stall_fetch_o    = 1'b1;
            icache_inv_req_o = 1'b1;
            if (icache_inv_ack_i) begin
               state_d     = (xcpt_pend_q | xcpt_flush_i) ? S_IDLE : S_FLUSH;
               xcpt_pend_d = 1'b0;
            end else if (xcpt_flush_i) begin
               xcpt_pend_d = 1'b1;
            end
         end
         S_FLUSH: begin
            stall_fetch_o    = 1'b1;
            flush_o          = ~xcpt_flush_i;
            redirect_valid_o = ~xcpt_flush_i;
            state_d          = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= S_IDLE;
         type_q      <= 2'd0;
         pc_q        <= '0;
         wd_q        <= '0;
         xcpt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         pc_q        <= pc_d;
         wd_q        <= wd_d;
         xcpt_pend_q <= xcpt_pend_d;
      end
   end

`ifdef SERIALIZE_PERF_EN
   logic [PERF_W-1:0] perf_serial_q, perf_serial_d;
   logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_serial_d = perf_serial_q + PERF_W'(flush_o);
      perf_stall_d  = perf_stall_q + PERF_W'(busy_o);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         perf_serial_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_serial_q <= perf_serial_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_serial_cnt_o = perf_serial_q;
   assign perf_stall_cnt_o  = perf_stall_q;
`else
   assign perf_serial_cnt_o = '0;
   assign perf_stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_serialize_ctrl_fsm.sv
// tb/tb_serialize_ctrl_fsm.sv - self-checking bench for serialize_ctrl_fsm
module tb_serialize_ctrl_fsm;
   localparam int ADDR_W = 64;
   localparam int TO     = 4;
   localparam int PERF_W = 32;
   localparam int LIMIT  = 40;

   typedef struct {
      int          typ;
      logic [63:0] pc;
      int          g, s, a, x;
      int          flush_k, end_k, drain, inv, to;
   } vec_t;

   typedef struct {
      int          flush_k, end_k, drain, inv, to, to_k, nflush, nrv, stall;
      logic [63:0] rpc;
   } obs_t;

   logic              clk_i = 1'b0;
   logic              rstn_i;
   logic              req_valid_i;
   logic [1:0]        req_type_i;
   logic [ADDR_W-1:0] req_pc_i;
   logic              req_ready_o;
   logic              gl_empty_i;
   logic              sb_empty_i;
   logic              drain_mem_o;
   logic              icache_inv_req_o;
   logic              icache_inv_ack_i;
   logic              xcpt_flush_i;
   logic              stall_fetch_o;
   logic              flush_o;
   logic              redirect_valid_o;
   logic [ADDR_W-1:0] redirect_pc_o;
   logic              busy_o;
   logic              timeout_o;
   logic [PERF_W-1:0] perf_serial_cnt_o;
   logic [PERF_W-1:0] perf_stall_cnt_o;

   int n_pass = 0;
   int n_total = 0;
   int exp_stall = 0;
   int exp_serial = 0;

   serialize_ctrl_fsm #(
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYCLES(TO),
      .PERF_W(PERF_W)
   ) dut (
      .clk_i(clk_i),
      .rstn_i(rstn_i),
      .req_valid_i(req_valid_i),
      .req_type_i(req_type_i),
      .req_pc_i(req_pc_i),
      .req_ready_o(req_ready_o),
      .gl_empty_i(gl_empty_i),
      .sb_empty_i(sb_empty_i),
      .drain_mem_o(drain_mem_o),
      .icache_inv_req_o(icache_inv_req_o),
      .icache_inv_ack_i(icache_inv_ack_i),
      .xcpt_flush_i(xcpt_flush_i),
      .stall_fetch_o(stall_fetch_o),
      .flush_o(flush_o),
      .redirect_valid_o(redirect_valid_o),
      .redirect_pc_o(redirect_pc_o),
      .busy_o(busy_o),
      .timeout_o(timeout_o),
      .perf_serial_cnt_o(perf_serial_cnt_o),
      .perf_stall_cnt_o(perf_stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic vec_t mk(input int typ, input logic [63:0] pc, input int g, input int s,
                               input int a, input int x, input int fk, input int ek,
                               input int dr, input int inv, input int to);
      vec_t v;
      v.typ = typ; v.pc = pc; v.g = g; v.s = s; v.a = a; v.x = x;
      v.flush_k = fk; v.end_k = ek; v.drain = dr; v.inv = inv; v.to = to;
      return v;
   endfunction

   // Timing predicted from the sequencing rules; k counts cycles after the accept cycle.
   function automatic vec_t model(input vec_t v);
      vec_t e;
      int   d, dlen, ack_k;
      bit   fi, csr;
      e = v;
      fi = (v.typ == 1);
      csr = (v.typ == 2);
      d = (csr || v.g > v.s) ? v.g : v.s;
      e.flush_k = -1;
      e.inv = 0;
      if (v.x >= 0 && v.x <= d) begin
         dlen = v.x + 1;
         e.end_k = v.x + 1;
      end else begin
         dlen = d + 1;
         if (fi) begin
            ack_k = d + 1 + v.a;
            e.inv = v.a + 1;
            if (v.x > d && v.x <= ack_k) begin
               e.end_k = ack_k + 1;
            end else begin
               e.end_k = ack_k + 2;
               if (v.x != ack_k + 1) e.flush_k = ack_k + 1;
            end
         end else begin
            e.end_k = d + 2;
            if (v.x != d + 1) e.flush_k = d + 1;
         end
      end
      e.drain = csr ? 0 : dlen;
      e.to = (dlen >= TO) ? 1 : 0;
      return e;
   endfunction

   task automatic run_seq(input vec_t v, output obs_t o);
      int inv_first;
      inv_first = -1;
      o.flush_k = -1; o.end_k = -2; o.drain = 0; o.inv = 0; o.to = 0;
      o.to_k = -1; o.nflush = 0; o.nrv = 0; o.stall = 0; o.rpc = '0;
      req_valid_i = 1'b1; req_type_i = 2'(v.typ); req_pc_i = v.pc;
      gl_empty_i = 1'b1; sb_empty_i = 1'b1; icache_inv_ack_i = 1'b0; xcpt_flush_i = 1'b0;
      #4;
      chk("ready_at_accept", req_ready_o, 1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      for (int k = 0; k < LIMIT; k++) begin
         gl_empty_i = (k >= v.g);
         sb_empty_i = (k >= v.s);
         xcpt_flush_i = (k == v.x);
         icache_inv_ack_i = (inv_first >= 0) && (k == inv_first + v.a);
         #4;
         if (!busy_o) begin
            o.end_k = k;
            break;
         end
         if (stall_fetch_o) o.stall++;
         if (drain_mem_o) o.drain++;
         if (icache_inv_req_o) begin
            if (inv_first < 0) inv_first = k;
            o.inv++;
         end
         if (flush_o) begin
            if (o.flush_k < 0) begin
               o.flush_k = k;
               o.rpc = redirect_pc_o;
            end
            o.nflush++;
         end
         if (redirect_valid_o) o.nrv++;
         if (timeout_o) begin
            if (o.to_k < 0) o.to_k = k;
            o.to++;
         end
         @(posedge clk_i); #1;
      end
      if (o.end_k == -2) $display("FAIL seq_bound: busy_o still high after %0d cycles", LIMIT);
      @(posedge clk_i); #1;
      xcpt_flush_i = 1'b0;
      icache_inv_ack_i = 1'b0;
   endtask

   task automatic compare(input string tag, input vec_t e, input obs_t o);
      chk({tag, "_end"}, 64'(o.end_k), 64'(e.end_k));
      chk({tag, "_flush_k"}, 64'(o.flush_k), 64'(e.flush_k));
      chk({tag, "_drain_mem"}, 64'(o.drain), 64'(e.drain));
      chk({tag, "_inv_req"}, 64'(o.inv), 64'(e.inv));
      chk({tag, "_timeouts"}, 64'(o.to), 64'(e.to));
      chk({tag, "_nflush"}, 64'(o.nflush), 64'(int'(e.flush_k >= 0)));
      chk({tag, "_nredirect"}, 64'(o.nrv), 64'(int'(e.flush_k >= 0)));
      chk({tag, "_stall"}, 64'(o.stall), 64'(e.end_k));
      if (e.flush_k >= 0) chk({tag, "_redirect_at_flush"}, o.rpc, e.pc + 64'd4);
      if (e.to != 0) chk({tag, "_timeout_k"}, 64'(o.to_k), 64'(TO - 1));
      chk({tag, "_redirect_hold"}, redirect_pc_o, e.pc + 64'd4);
      exp_stall += e.end_k;
      exp_serial += (e.flush_k >= 0) ? 1 : 0;
   endtask

   initial begin
      vec_t tbl[10];
      vec_t v, e;
      obs_t o;
      rstn_i = 1'b0; req_valid_i = 1'b0; req_type_i = 2'd0; req_pc_i = '0;
      gl_empty_i = 1'b0; sb_empty_i = 1'b0; icache_inv_ack_i = 1'b0; xcpt_flush_i = 1'b0;

      //            typ pc                       g   s  a   x  flush end drain inv to
      tbl[0] = mk(0, 64'h0000_0000_8000_0000, 0,  0, 1, -1,   1,  2,  1,  0, 0);
      tbl[1] = mk(1, 64'h0000_0000_0000_1000, 0,  5, 3, -1,  10, 11,  6,  4, 1);
      tbl[2] = mk(2, 64'h0000_0000_0000_2000, 0, 99, 1, -1,   1,  2,  0,  0, 0);
      tbl[3] = mk(0, 64'hFFFF_FFFF_FFFF_FFFC, 0,  0, 1, -1,   1,  2,  1,  0, 0);
      tbl[4] = mk(0, 64'h0000_0000_0000_3000, 3,  2, 1,  1,  -1,  2,  2,  0, 0);
      tbl[5] = mk(1, 64'h0000_0000_0000_4000, 0,  0, 4,  2,  -1,  6,  1,  5, 0);
      tbl[6] = mk(0, 64'h0000_0000_0000_5000, 10, 0, 1, -1,  11, 12, 11,  0, 1);
      tbl[7] = mk(3, 64'h0000_0000_0000_6000, 2,  4, 1, -1,   5,  6,  5,  0, 1);
      tbl[8] = mk(0, 64'h0000_0000_0000_7000, 0,  0, 1,  1,  -1,  2,  1,  0, 0);
      tbl[9] = mk(2, 64'h0000_0000_0000_8000, 2,  9, 1, -1,   3,  4,  0,  0, 0);

      #12;
      chk("reset_outputs", {57'd0, busy_o, stall_fetch_o, drain_mem_o, icache_inv_req_o,
                            flush_o, redirect_valid_o, timeout_o}, 64'd0);
      chk("reset_redirect_pc", redirect_pc_o, 64'd0);
      chk("reset_perf_serial", 64'(perf_serial_cnt_o), 64'd0);
      chk("reset_perf_stall", 64'(perf_stall_cnt_o), 64'd0);
      @(posedge clk_i); #1;
      rstn_i = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_seq(tbl[i], o);
         compare($sformatf("vec%0d", i), tbl[i], o);
      end

      // Exception in IDLE blocks the request; a stray ack is ignored.
      req_valid_i = 1'b1; req_type_i = 2'd1; req_pc_i = 64'h9000;
      xcpt_flush_i = 1'b1; icache_inv_ack_i = 1'b1;
      #4;
      chk("idle_xcpt_ready", req_ready_o, 0);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0; xcpt_flush_i = 1'b0; icache_inv_ack_i = 1'b0;
      #4;
      chk("idle_xcpt_dropped", {61'd0, busy_o, icache_inv_req_o, flush_o}, 64'd0);
      chk("idle_xcpt_pc_stable", redirect_pc_o, tbl[9].pc + 64'd4);
      @(posedge clk_i); #1;

      for (int i = 0; i < 150; i++) begin
         v = mk($urandom_range(3), {$urandom, $urandom}, $urandom_range(6), $urandom_range(6),
                $urandom_range(4, 1), ($urandom_range(3) == 0) ? $urandom_range(12) : -1,
                0, 0, 0, 0, 0);
         if (i % 16 == 0) v.pc = 64'hFFFF_FFFF_FFFF_FFFC - 64'(4 * $urandom_range(1));
         e = model(v);
         run_seq(e, o);
         compare($sformatf("rnd%0d", i), e, o);
      end

`ifdef SERIALIZE_PERF_EN
      chk("perf_serial", 64'(perf_serial_cnt_o), 64'(exp_serial));
      chk("perf_stall", 64'(perf_stall_cnt_o), 64'(exp_stall));
`else
      chk("perf_serial_tied", 64'(perf_serial_cnt_o), 64'd0);
      chk("perf_stall_tied", 64'(perf_stall_cnt_o), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
